payload_writer: RTL
===================

Name: payload_writer

Overview:
- Ingress-side stage directly upstream of the payload buffer.
- Accepts a byte stream framed by start-of-packet/end-of-packet and packs bytes into buffer-width blocks.
- Issues one write-mode buffer access per block and tracks free-block credits.
- After the last block, captures the chain address returned by the buffer and emits a packet descriptor {address, length, ttl} to the dispatcher queue.

Parameters:
DATA_BYTES, 8, bytes per payload block (Data_t width / 8)
ADDR_W, 12, buffer address width (Address_t)
BCNT_W, 4, byteCount width; must hold DATA_BYTES
TTL_W, 4, ttl width (Ttl_t)
LEN_W, 16, descriptor byte-length width
NUM_BLOCKS, 4096, buffer depth; free-credit reset value

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  ingress byte valid
in_ready  out  1  ingress byte accepted when in_valid && in_ready
in_data  in  8  ingress byte
in_sop  in  1  first byte of packet
in_eop  in  1  last byte of packet
in_ttl  in  TTL_W  packet ttl, sampled with the sop byte
buf_grant  in  1  buffer arbiter grant; no access issued while low
buf_enable  out  1  buffer enable, one-cycle pulse per block
buf_readWrite  out  1  1 = write mode; driven 1 only with buf_enable
buf_data  out  DATA_BYTES*8  packed block; byte k in bits [8k+7:8k]; unused lanes zero
buf_ttl  out  TTL_W  block ttl
buf_byteCount  out  BCNT_W  valid bytes in block, 1..DATA_BYTES
buf_isLast  out  1  block holds the packet's final byte
buf_address  in  ADDR_W  chain address from buffer; valid the cycle after a write
free_inc  in  1  one block returned to the free list (read side)
desc_valid  out  1  descriptor valid
desc_ready  in  1  descriptor accepted
desc_address  out  ADDR_W  chain address of packet
desc_length  out  LEN_W  packet length in bytes, saturating
desc_ttl  out  TTL_W  packet ttl
err_proto  out  1  one-cycle pulse: byte accepted outside a packet (dropped)
err_credit  out  1  one-cycle pulse: free_inc while credits already NUM_BLOCKS

Behaviour:
- Reset (reset=0, async):
  - FSM to IDLE.
  - All outputs 0 except in_ready=1.
  - free_count = NUM_BLOCKS; pack register, lane index, length cleared.
- FSM states: IDLE, FILL, ISSUE, WAIT_ADDR, DESC.
- IDLE:
  - in_ready=1.
  - Accepted byte with in_sop: latch in_ttl, write lane 0, length=1. If in_eop also set, go ISSUE (byteCount=1, isLast=1); otherwise go FILL.
  - Accepted byte without in_sop: dropped, err_proto pulse, stay IDLE.
- FILL:
  - in_ready=1; each accepted byte goes into the next lane; length increments, saturating at 2^LEN_W-1.
  - in_sop inside a packet is ignored (byte treated as data).
  - Lane DATA_BYTES-1 written, or in_eop: go ISSUE; byteCount = lanes filled; isLast = in_eop.
- ISSUE:
  - in_ready=0.
  - When buf_grant && free_count>0: buf_enable=1 and buf_readWrite=1 for exactly that cycle, buf_* stable; free_count decrements.
  - Then: not last -> FILL with lanes cleared; last -> WAIT_ADDR.
  - Otherwise hold all buf_* stable with buf_enable=0.
- WAIT_ADDR: one cycle; capture buf_address into desc_address; go DESC.
- DESC:
  - desc_valid=1; desc_* held stable until desc_ready.
  - On handshake go IDLE; in_ready reasserts the following cycle.
- Latency: last byte accepted -> buf_enable pulse at earliest next cycle -> desc_valid 2 cycles after that pulse.
- Credits:
  - free_count width ADDR_W+1.
  - Issue and free_inc in the same cycle: count unchanged.
  - free_inc at NUM_BLOCKS: ignored, err_credit pulse.
- Write mode never issues with free_count=0; the stall persists until free_inc.
- Reset mid-packet: partial packet discarded, no descriptor, credits restored to NUM_BLOCKS.

Optional Feature:
- Macro PAYLOAD_WRITER_STATS_EN.
- Defined: adds outputs stat_packets (32 bits, +1 per descriptor handshake), stat_blocks (32 bits, +1 per buf_enable pulse) and stat_stall (32 bits, +1 per ISSUE cycle without an access). All wrap at 2^32 and clear on reset.
- Undefined: the three ports still exist, tied to 0, and no counter logic is present.

Test Plan:
- 3-byte packet 0xA1,0xA2,0xA3 (sop on first, eop on last), ttl=5, buf_address=0x123 -> single pulse with buf_data[23:0]=0xA3A2A1, upper lanes 0, byteCount=3, isLast=1; desc {0x123, 3, 5}.
- 17-byte packet -> three pulses with byteCount 8, 8, 1; isLast only on the third; desc_length=17; free_count = NUM_BLOCKS-3.
- buf_grant low for 4 cycles in ISSUE -> no buf_enable, buf_* stable, in_ready=0; pulse on first granted cycle.
- NUM_BLOCKS=2, 24-byte packet -> stalls after 2 blocks; free_inc pulse -> third block issues; simultaneous free_inc with an issue leaves count unchanged; free_inc at 2 -> err_credit.
- Byte without sop in IDLE -> err_proto pulse, no buffer access; desc_ready held low 5 cycles -> desc stable, in_ready=0 until handshake.
- Reset asserted mid-FILL -> outputs return to reset values immediately; next packet produces correct descriptor.

Source files
------------

// File: rtl/payload_writer.sv
// ---------------------------------------------------------------------------
// payload_writer
//
// Ingress stage that sits directly upstream of the payload buffer. It takes a
// byte stream framed by sop/eop and packs the bytes into DATA_BYTES-wide
// blocks. It issues one write-mode buffer access per block and tracks
// free-block credits. After the last block of a packet it captures the chain
// address returned by the buffer and offers a {address, length, ttl}
// descriptor to the dispatcher queue.
//
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready       ingress byte handshake
//   in_data/in_sop/in_eop   ingress byte and packet framing
//   in_ttl                  packet ttl, sampled with the sop byte
//   buf_grant               buffer arbiter grant
//   buf_enable              one-cycle access strobe, one per block
//   buf_readWrite           1 = write; high only together with buf_enable
//   buf_data                packed block, byte k in bits [8k+7:8k]
//   buf_ttl/buf_byteCount   block ttl and number of valid bytes
//   buf_isLast              block carries the packet's final byte
//   buf_address             chain address, valid the cycle after the last write
//   free_inc                one block returned to the free list
//   desc_*                  packet descriptor with valid/ready handshake
//   err_proto               pulse: byte outside a packet was dropped
//   err_credit              pulse: free_inc while credits already full
//   stat_packets/blocks/stall  statistics counters
//
// Optional feature: define PAYLOAD_WRITER_STATS_EN to build the statistics
// counters. Without it the stat_* ports exist but are tied to zero.
// ---------------------------------------------------------------------------
module payload_writer #(
    parameter int DATA_BYTES = 8,
    parameter int ADDR_W     = 12,
    parameter int BCNT_W     = 4,
    parameter int TTL_W      = 4,
    parameter int LEN_W      = 16,
    parameter int NUM_BLOCKS = 4096
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [7:0]              in_data,
    input  logic                    in_sop,
    input  logic                    in_eop,
    input  logic [TTL_W-1:0]        in_ttl,
    input  logic                    buf_grant,
    output logic                    buf_enable,
    output logic                    buf_readWrite,
    output logic [DATA_BYTES*8-1:0] buf_data,
    output logic [TTL_W-1:0]        buf_ttl,
    output logic [BCNT_W-1:0]       buf_byteCount,
    output logic                    buf_isLast,
    input  logic [ADDR_W-1:0]       buf_address,
    input  logic                    free_inc,
    output logic                    desc_valid,
    input  logic                    desc_ready,
    output logic [ADDR_W-1:0]       desc_address,
    output logic [LEN_W-1:0]        desc_length,
    output logic [TTL_W-1:0]        desc_ttl,
    output logic                    err_proto,
    output logic                    err_credit,
    output logic [31:0]             stat_packets,
    output logic [31:0]             stat_blocks,
    output logic [31:0]             stat_stall
);

    localparam int CNT_W = ADDR_W + 1;
    localparam int PACK_W = DATA_BYTES * 8;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FILL      = 3'd1;
    localparam logic [2:0] S_ISSUE     = 3'd2;
    localparam logic [2:0] S_WAIT_ADDR = 3'd3;
    localparam logic [2:0] S_DESC      = 3'd4;

    localparam logic [CNT_W-1:0]  FREE_FULL = CNT_W'(NUM_BLOCKS);
    localparam logic [BCNT_W-1:0] LANE_LAST = BCNT_W'(DATA_BYTES - 1);

    // Saturating byte-length increment: a packet longer than the field can
    // express reports the maximum value rather than wrapping.
    function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
        logic [LEN_W-1:0] r;
        if (v == {LEN_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + LEN_W'(1);
        end
        return r;
    endfunction

    // Write one byte into the selected lane, leaving the other lanes intact.
    function automatic logic [PACK_W-1:0] put_lane(
        input logic [PACK_W-1:0] pack,
        input logic [BCNT_W-1:0] lane,
        input logic [7:0]        b
    );
        logic [PACK_W-1:0] r;
        r = pack;
        for (int k = 0; k < DATA_BYTES; k++) begin
            if (lane == BCNT_W'(k)) begin
                r[8*k +: 8] = b;
            end else begin
                r[8*k +: 8] = pack[8*k +: 8];
            end
        end
        return r;
    endfunction

    logic [2:0]        state_q,      state_d;
    logic [PACK_W-1:0] pack_q,       pack_d;
    logic [BCNT_W-1:0] lane_q,       lane_d;      // lanes filled so far
    logic              last_q,       last_d;
    logic [TTL_W-1:0]  ttl_q,        ttl_d;
    logic [LEN_W-1:0]  len_q,        len_d;
    logic [CNT_W-1:0]  free_q,       free_d;
    logic [ADDR_W-1:0] desc_addr_q,  desc_addr_d;
    logic [LEN_W-1:0]  desc_len_q,   desc_len_d;
    logic [TTL_W-1:0]  desc_ttl_q,   desc_ttl_d;
    logic              err_proto_q,  err_proto_d;
    logic              err_credit_q, err_credit_d;

    logic in_ready_s;
    logic accept_s;
    logic issue_s;

    // Handshake decode: bytes are taken only while a block is being filled,
    // and an access goes out only with both a grant and a free block.
    always_comb begin
        in_ready_s = (state_q == S_IDLE) || (state_q == S_FILL);
        accept_s   = in_valid && in_ready_s;
        issue_s    = (state_q == S_ISSUE) && buf_grant && (free_q != {CNT_W{1'b0}});
    end

    // Packet FSM: byte packing, block issue, address capture and descriptor.
    always_comb begin
        state_d     = state_q;
        pack_d      = pack_q;
        lane_d      = lane_q;
        last_d      = last_q;
        ttl_d       = ttl_q;
        len_d       = len_q;
        desc_addr_d = desc_addr_q;
        desc_len_d  = desc_len_q;
        desc_ttl_d  = desc_ttl_q;
        err_proto_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    if (in_sop) begin
                        // First byte always lands in lane 0 of a cleared block.
                        ttl_d  = in_ttl;
                        pack_d = {{(PACK_W-8){1'b0}}, in_data};
                        lane_d = BCNT_W'(1);
                        len_d  = LEN_W'(1);
                        last_d = in_eop;
                        if (in_eop) begin
                            state_d = S_ISSUE;
                        end else begin
                            state_d = S_FILL;
                        end
                    end else begin
                        err_proto_d = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FILL: begin
                if (accept_s) begin
                    // A stray sop inside a packet is treated as plain data.
                    pack_d = put_lane(pack_q, lane_q, in_data);
                    lane_d = lane_q + BCNT_W'(1);
                    len_d  = sat_inc(len_q);
                    if ((lane_q == LANE_LAST) || in_eop) begin
                        last_d  = in_eop;
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_FILL;
                    end
                end else begin
                    state_d = S_FILL;
                end
            end
            S_ISSUE: begin
                if (issue_s) begin
                    if (last_q) begin
                        state_d = S_WAIT_ADDR;
                    end else begin
                        // Next block starts from empty lanes so unused lanes read zero.
                        pack_d  = {PACK_W{1'b0}};
                        lane_d  = {BCNT_W{1'b0}};
                        state_d = S_FILL;
                    end
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_WAIT_ADDR: begin
                // Buffer returns the chain address in the cycle after the last write.
                desc_addr_d = buf_address;
                desc_len_d  = len_q;
                desc_ttl_d  = ttl_q;
                state_d     = S_DESC;
            end
            S_DESC: begin
                if (desc_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DESC;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Free-block credit accounting; a simultaneous issue and return cancel out.
    always_comb begin
        free_d       = free_q;
        err_credit_d = 1'b0;
        case ({issue_s, free_inc})
            2'b10: begin
                free_d = free_q - CNT_W'(1);
            end
            2'b01: begin
                if (free_q == FREE_FULL) begin
                    err_credit_d = 1'b1;
                end else begin
                    free_d = free_q + CNT_W'(1);
                end
            end
            default: begin
                free_d = free_q;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            pack_q       <= {PACK_W{1'b0}};
            lane_q       <= {BCNT_W{1'b0}};
            last_q       <= 1'b0;
            ttl_q        <= {TTL_W{1'b0}};
            len_q        <= {LEN_W{1'b0}};
            free_q       <= FREE_FULL;
            desc_addr_q  <= {ADDR_W{1'b0}};
            desc_len_q   <= {LEN_W{1'b0}};
            desc_ttl_q   <= {TTL_W{1'b0}};
            err_proto_q  <= 1'b0;
            err_credit_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pack_q       <= pack_d;
            lane_q       <= lane_d;
            last_q       <= last_d;
            ttl_q        <= ttl_d;
            len_q        <= len_d;
            free_q       <= free_d;
            desc_addr_q  <= desc_addr_d;
            desc_len_q   <= desc_len_d;
            desc_ttl_q   <= desc_ttl_d;
            err_proto_q  <= err_proto_d;
            err_credit_q <= err_credit_d;
        end
    end

    // The access strobe follows the grant in the same cycle so a block goes
    // out on the first granted cycle; everything else comes from flops.
    assign in_ready      = in_ready_s;
    assign buf_enable    = issue_s;
    assign buf_readWrite = issue_s;
    assign buf_data      = pack_q;
    assign buf_ttl       = ttl_q;
    assign buf_byteCount = lane_q;
    assign buf_isLast    = last_q;
    assign desc_valid    = (state_q == S_DESC);
    assign desc_address  = desc_addr_q;
    assign desc_length   = desc_len_q;
    assign desc_ttl      = desc_ttl_q;
    assign err_proto     = err_proto_q;
    assign err_credit    = err_credit_q;

`ifdef PAYLOAD_WRITER_STATS_EN
    logic [31:0] stat_packets_q, stat_packets_d;
    logic [31:0] stat_blocks_q,  stat_blocks_d;
    logic [31:0] stat_stall_q,   stat_stall_d;

    // Statistics increments; all counters wrap naturally at 2^32.
    always_comb begin
        stat_packets_d = stat_packets_q;
        stat_blocks_d  = stat_blocks_q;
        stat_stall_d   = stat_stall_q;
        if ((state_q == S_DESC) && desc_ready) begin
            stat_packets_d = stat_packets_q + 32'd1;
        end else begin
            stat_packets_d = stat_packets_q;
        end
        if (issue_s) begin
            stat_blocks_d = stat_blocks_q + 32'd1;
        end else begin
            stat_blocks_d = stat_blocks_q;
        end
        if ((state_q == S_ISSUE) && !issue_s) begin
            stat_stall_d = stat_stall_q + 32'd1;
        end else begin
            stat_stall_d = stat_stall_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stat_packets_q <= 32'd0;
            stat_blocks_q  <= 32'd0;
            stat_stall_q   <= 32'd0;
        end else begin
            stat_packets_q <= stat_packets_d;
            stat_blocks_q  <= stat_blocks_d;
            stat_stall_q   <= stat_stall_d;
        end
    end

    assign stat_packets = stat_packets_q;
    assign stat_blocks  = stat_blocks_q;
    assign stat_stall   = stat_stall_q;
`else
    assign stat_packets = 32'd0;
    assign stat_blocks  = 32'd0;
    assign stat_stall   = 32'd0;
`endif

endmodule
